q2_mem_arbiter: RTL and testbench
=================================

# q2_mem_arbiter

Two-port arbiter that shares the single 12-bit q2 RAM between the CPU datapath and a DMA/loader port (front-panel loader, I2C boot loader). It grants one requester at a time and sequences each access as setup, strobe and hold phases on the RAM chip-enable, output-enable and write-enable lines. It completes each transfer with a one-cycle acknowledge. The block sits between the CPU memory interface and `q2_ram`; the top level owns dbus tri-stating, driven from `ram_drive`.

## Interface

Parameters:
- `SETUP_CYCLES`, default 1: cycles of address/data setup before the strobe. Legal range 1..4.
- `STROBE_CYCLES`, default 2: width of the `ram_oe`/`ram_we` pulse. Legal range 1..8.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, **synchronous, active-low**.
- `cpu_req` / `dma_req`  in  1  access request; held until the matching ack.
- `cpu_we` / `dma_we`  in  1  1 = write, 0 = read.
- `cpu_addr` / `dma_addr`  in  12  word address.
- `cpu_wdata` / `dma_wdata`  in  12  write data.
- `cpu_ack` / `dma_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata` / `dma_rdata`  out  12  registered read data.
- `ram_ce`, `ram_oe`, `ram_we`  out  1  RAM strobes, active-high; the top level inverts them as the RAM requires.
- `ram_addr`  out  12  latched address.
- `ram_wdata`  out  12  latched write data.
- `ram_drive`  out  1  dbus output enable for writes.
- `ram_rdata`  in  12  dbus read value.
- `grant`  out  1  0 = CPU owns the bus, 1 = DMA owns the bus; valid while `busy`.
- `busy`  out  1  high in any state except IDLE.

## Operation

- FSM states: IDLE → SETUP → STROBE → HOLD → IDLE.
- **IDLE**
  - If either req is high, arbitrate (see Configuration).
  - Latch the winner's addr, we and wdata; set `grant`; go to SETUP.
  - With no request, stay in IDLE.
- **SETUP** (`SETUP_CYCLES` cycles)
  - `ram_ce`=1 and `ram_addr` valid.
  - `ram_drive`=1 if write.
- **STROBE** (`STROBE_CYCLES` cycles)
  - `ram_we`=1 for a write, `ram_oe`=1 for a read.
  - On a read, `ram_rdata` is sampled on the final STROBE edge into the winner's rdata register.
- **HOLD** (1 cycle)
  - `ram_oe`=`ram_we`=0.
  - `ram_ce` and `ram_drive` are held.
  - Winner's ack=1.
  - Next state is IDLE.
- A shared 3-bit phase counter times SETUP and STROBE.
- `ram_addr` and `ram_wdata` hold their last value in IDLE.
- `cpu_rdata` and `dma_rdata` hold until the next read by the same requester; a write never alters them.
- A req dropped before its ack does not abort the transfer; the ack is still issued.
- The loser's req is ignored until the next IDLE cycle; no request is queued.
- `rst` low, sampled on any edge, including mid-transfer:
  - state←IDLE; all strobes, `ram_drive`, acks, `busy` and `grant`←0.
  - `ram_addr`, `ram_wdata`, `cpu_rdata` and `dma_rdata`←0.
  - last-grant←DMA.
  - An interrupted transfer gets no ack.

## Timing

- All outputs are registered; no combinational path from req to any output.
- Request sampled high in IDLE at edge t:
  - SETUP occupies cycles t+1 .. t+SETUP_CYCLES.
  - STROBE follows immediately.
  - HOLD/ack at cycle t+SETUP_CYCLES+STROBE_CYCLES+1. Defaults give ack at t+4.
- rdata is valid in the ack cycle and after it.
- Minimum request-to-request period is SETUP_CYCLES+STROBE_CYCLES+2 cycles, because one IDLE cycle is mandatory between transfers. Defaults give 5 cycles.
- `busy` rises at t+1 and falls in the cycle after HOLD.

## Configuration

- `Q2_ARB_RR_EN` defined: round-robin arbitration.
  - When both requests are high in IDLE, the requester not granted last wins.
  - A sole requester always wins.
  - last-grant updates at each grant.
- `Q2_ARB_RR_EN` undefined: fixed priority, CPU always wins.
  - DMA is served only in IDLE cycles where `cpu_req`=0.
  - A continuous `cpu_req` starves DMA; this is the intended behaviour.

## Test plan

1. **Reset mid-write:** DMA write in progress, `rst`=0 for 2 cycles during STROBE → next edge `ram_we`=`ram_ce`=`ram_drive`=`busy`=0, `dma_ack` never pulses; after release a CPU read proceeds normally.
2. **CPU read:** `cpu_addr`=0x123, RAM model returns 0xABC, defaults → `ram_ce` t+1..t+4, `ram_oe` t+2..t+3, `cpu_ack` at t+4 only, `cpu_rdata`=0xABC, `dma_rdata` unchanged.
3. **DMA write:** `dma_addr`=0x7FF, `dma_wdata`=0x555 → `ram_drive` t+1..t+4, `ram_we` t+2..t+3, `ram_wdata`=0x555, `grant`=1, `dma_ack` at t+4.
4. **Contention:** both reqs held through 4 transfers → without the macro grants CPU,CPU,CPU,CPU; with `Q2_ARB_RR_EN` grants CPU,DMA,CPU,DMA; acks every 5 cycles.
5. **Request withdrawal:** `cpu_req` high for only 1 cycle → full transfer runs, `cpu_ack` pulses at t+4, FSM returns to IDLE with no second transfer.
6. **Parameter sweep:** `SETUP_CYCLES`=3, `STROBE_CYCLES`=1 → `ram_oe` only at t+4, ack at t+5; `SETUP_CYCLES`=4, `STROBE_CYCLES`=8 → ack at t+13.

Source files
------------

// File: rtl/q2_mem_arbiter.sv
// q2_mem_arbiter: shares the 12-bit q2 RAM between the CPU datapath and the
// DMA/loader port, sequencing each access as SETUP -> STROBE -> HOLD with a
// one-cycle acknowledge in HOLD. All outputs are registered.
//
// Optional feature macro: Q2_ARB_RR_EN
//   defined   -> round-robin arbitration between CPU and DMA
//   undefined -> fixed priority, CPU always wins
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no transfer; arbitrate and latch the winner when a req is seen
// SETUP  | ram_ce and address (and write data drive) settle before strobe
// STROBE | ram_oe (read) or ram_we (write) asserted; read data captured
//        | on the last STROBE edge
// HOLD   | strobes released, ce/drive held, winner's ack pulses
module q2_mem_arbiter #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [11:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [11:0] dma_addr,
  input  logic [11:0] dma_wdata,
  output logic        dma_ack,
  output logic [11:0] dma_rdata,
  output logic        ram_ce,
  output logic        ram_oe,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [11:0] ram_wdata,
  output logic        ram_drive,
  input  logic [11:0] ram_rdata,
  output logic        grant,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // Phase counter counts down to zero; load values are cycle counts minus one.
  localparam logic [2:0] SETUP_LOAD  = 3'(SETUP_CYCLES - 1);
  localparam logic [2:0] STROBE_LOAD = 3'(STROBE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [2:0]  phase, phase_nxt;
  logic        xfer_we, xfer_we_nxt;
  logic        grant_nxt;
  logic        ce_nxt, oe_nxt, rwe_nxt, drive_nxt, busy_nxt;
  logic        cpu_ack_nxt, dma_ack_nxt;
  logic [11:0] addr_nxt, wdata_nxt;
  logic [11:0] cpu_rdata_nxt, dma_rdata_nxt;
  logic        win_dma;

`ifdef Q2_ARB_RR_EN
  // 1 = DMA was granted most recently; reset value favours the CPU first.
  logic last_dma, last_dma_nxt;

  // On contention the requester not granted last wins; a sole requester wins.
  assign win_dma = dma_req & (~cpu_req | ~last_dma);
`else
  // Fixed priority: DMA only wins in cycles where the CPU is not requesting.
  assign win_dma = ~cpu_req;
`endif

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    xfer_we_nxt   = xfer_we;
    grant_nxt     = grant;
    ce_nxt        = ram_ce;
    oe_nxt        = ram_oe;
    rwe_nxt       = ram_we;
    drive_nxt     = ram_drive;
    busy_nxt      = busy;
    cpu_ack_nxt   = 1'b0;
    dma_ack_nxt   = 1'b0;
    addr_nxt      = ram_addr;
    wdata_nxt     = ram_wdata;
    cpu_rdata_nxt = cpu_rdata;
    dma_rdata_nxt = dma_rdata;
`ifdef Q2_ARB_RR_EN
    last_dma_nxt  = last_dma;
`endif
    case (state)
      S_IDLE: begin
        if (cpu_req | dma_req) begin
          state_nxt   = S_SETUP;
          phase_nxt   = SETUP_LOAD;
          grant_nxt   = win_dma;
          xfer_we_nxt = win_dma ? dma_we    : cpu_we;
          addr_nxt    = win_dma ? dma_addr  : cpu_addr;
          wdata_nxt   = win_dma ? dma_wdata : cpu_wdata;
          ce_nxt      = 1'b1;
          drive_nxt   = win_dma ? dma_we    : cpu_we;
          busy_nxt    = 1'b1;
          oe_nxt      = 1'b0;
          rwe_nxt     = 1'b0;
`ifdef Q2_ARB_RR_EN
          last_dma_nxt = win_dma;
`endif
        end
      end
      S_SETUP: begin
        if (phase == 3'd0) begin
          state_nxt = S_STROBE;
          phase_nxt = STROBE_LOAD;
          oe_nxt    = ~xfer_we;
          rwe_nxt   = xfer_we;
        end else begin
          phase_nxt = phase - 3'd1;
        end
      end
      S_STROBE: begin
        if (phase == 3'd0) begin
          state_nxt = S_HOLD;
          oe_nxt    = 1'b0;
          rwe_nxt   = 1'b0;
          if (grant) dma_ack_nxt = 1'b1;
          else       cpu_ack_nxt = 1'b1;
          if (!xfer_we) begin
            if (grant) dma_rdata_nxt = ram_rdata;
            else       cpu_rdata_nxt = ram_rdata;
          end
        end else begin
          phase_nxt = phase - 3'd1;
        end
      end
      S_HOLD: begin
        state_nxt = S_IDLE;
        ce_nxt    = 1'b0;
        drive_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
      default: begin
        state_nxt = S_IDLE;
        ce_nxt    = 1'b0;
        oe_nxt    = 1'b0;
        rwe_nxt   = 1'b0;
        drive_nxt = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State register and phase counter; reset aborts any transfer in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      phase   <= 3'd0;
      xfer_we <= 1'b0;
    end else begin
      state   <= state_nxt;
      phase   <= phase_nxt;
      xfer_we <= xfer_we_nxt;
    end
  end

  // Registered outputs, latched address/data and per-requester read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      grant     <= 1'b0;
      ram_ce    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_we    <= 1'b0;
      ram_drive <= 1'b0;
      busy      <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      ram_addr  <= 12'h000;
      ram_wdata <= 12'h000;
      cpu_rdata <= 12'h000;
      dma_rdata <= 12'h000;
    end else begin
      grant     <= grant_nxt;
      ram_ce    <= ce_nxt;
      ram_oe    <= oe_nxt;
      ram_we    <= rwe_nxt;
      ram_drive <= drive_nxt;
      busy      <= busy_nxt;
      cpu_ack   <= cpu_ack_nxt;
      dma_ack   <= dma_ack_nxt;
      ram_addr  <= addr_nxt;
      ram_wdata <= wdata_nxt;
      cpu_rdata <= cpu_rdata_nxt;
      dma_rdata <= dma_rdata_nxt;
    end
  end

`ifdef Q2_ARB_RR_EN
  // Last-grant tracker for round-robin; reset points at DMA.
  always_ff @(posedge clk) begin
    if (!rst) last_dma <= 1'b1;
    else      last_dma <= last_dma_nxt;
  end
`endif

endmodule

// File: tb/tb_q2_mem_arbiter.sv
// Directed bench for q2_mem_arbiter: default instance plus two parameter
// variants (3/1 and 4/8). Cycle k means the cycle after the k-th edge
// counted from the edge that samples the request (k=1 is the first SETUP).
module tb_q2_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [11:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [11:0] ram_val;

  logic        cpu_ack, dma_ack, ram_ce, ram_oe, ram_we, ram_drive, grant, busy;
  logic [11:0] cpu_rdata, dma_rdata, ram_addr, ram_wdata;

  logic        req_b, ack_b, dack_b, ce_b, oe_b, we_b, drv_b, gnt_b, busy_b;
  logic [11:0] rd_b, drd_b, addr_b, wd_b;
  logic        req_c, ack_c, dack_c, ce_c, oe_c, we_c, drv_c, gnt_c, busy_c;
  logic [11:0] rd_c, drd_c, addr_c, wd_c;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  q2_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .ram_ce(ram_ce), .ram_oe(ram_oe), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_drive(ram_drive), .ram_rdata(ram_val),
    .grant(grant), .busy(busy)
  );

  q2_mem_arbiter #(.SETUP_CYCLES(3), .STROBE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(req_b), .cpu_we(1'b0), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(ack_b), .cpu_rdata(rd_b),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dack_b), .dma_rdata(drd_b),
    .ram_ce(ce_b), .ram_oe(oe_b), .ram_we(we_b), .ram_addr(addr_b),
    .ram_wdata(wd_b), .ram_drive(drv_b), .ram_rdata(ram_val),
    .grant(gnt_b), .busy(busy_b)
  );

  q2_mem_arbiter #(.SETUP_CYCLES(4), .STROBE_CYCLES(8)) dut_c (
    .clk(clk), .rst(rst),
    .cpu_req(req_c), .cpu_we(1'b0), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(ack_c), .cpu_rdata(rd_c),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dack_c), .dma_rdata(drd_c),
    .ram_ce(ce_c), .ram_oe(oe_c), .ram_we(we_c), .ram_addr(addr_c),
    .ram_wdata(wd_c), .ram_drive(drv_c), .ram_rdata(ram_val),
    .grant(gnt_c), .busy(busy_c)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic exp_dma;
    rst = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h000; cpu_wdata = 12'h000;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 12'h000; dma_wdata = 12'h000;
    req_b = 1'b0; req_c = 1'b0; ram_val = 12'h000;

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_ce", ram_ce, 0);
    chk("rst_oe", ram_oe, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_drive", ram_drive, 0);
    chk("rst_grant", grant, 0);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_dma_ack", dma_ack, 0);
    chk("rst_addr", ram_addr, 12'h000);
    chk("rst_cpu_rdata", cpu_rdata, 12'h000);
    chk("rst_dma_rdata", dma_rdata, 12'h000);
    rst = 1'b1;
    tick();

    // CPU read: addr 0x123, RAM returns 0xABC
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h123; ram_val = 12'hABC;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("rd_ce_k%0d", k), ram_ce, (k >= 1 && k <= 4));
      chk($sformatf("rd_oe_k%0d", k), ram_oe, (k == 2 || k == 3));
      chk($sformatf("rd_we_k%0d", k), ram_we, 0);
      chk($sformatf("rd_drive_k%0d", k), ram_drive, 0);
      chk($sformatf("rd_ack_k%0d", k), cpu_ack, (k == 4));
      chk($sformatf("rd_dack_k%0d", k), dma_ack, 0);
      chk($sformatf("rd_busy_k%0d", k), busy, (k <= 4));
      if (k <= 4) chk($sformatf("rd_grant_k%0d", k), grant, 0);
      if (k == 1) chk("rd_addr", ram_addr, 12'h123);
      if (k == 4) begin
        chk("rd_cpu_rdata", cpu_rdata, 12'hABC);
        chk("rd_dma_rdata", dma_rdata, 12'h000);
        cpu_req = 1'b0;
      end
    end
    chk("rd_addr_hold_idle", ram_addr, 12'h123);

    // DMA write: addr 0x7FF, data 0x555
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h7FF; dma_wdata = 12'h555;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("wr_drive_k%0d", k), ram_drive, (k >= 1 && k <= 4));
      chk($sformatf("wr_ce_k%0d", k), ram_ce, (k >= 1 && k <= 4));
      chk($sformatf("wr_we_k%0d", k), ram_we, (k == 2 || k == 3));
      chk($sformatf("wr_oe_k%0d", k), ram_oe, 0);
      chk($sformatf("wr_dack_k%0d", k), dma_ack, (k == 4));
      chk($sformatf("wr_cack_k%0d", k), cpu_ack, 0);
      if (k <= 4) chk($sformatf("wr_grant_k%0d", k), grant, 1);
      if (k == 1) begin
        chk("wr_addr", ram_addr, 12'h7FF);
        chk("wr_wdata", ram_wdata, 12'h555);
      end
      if (k == 4) begin
        chk("wr_cpu_rdata_kept", cpu_rdata, 12'hABC);
        chk("wr_dma_rdata_kept", dma_rdata, 12'h000);
        dma_req = 1'b0;
      end
    end
    chk("wr_wdata_hold_idle", ram_wdata, 12'h555);

    // Contention: both held through four transfers
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h010;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 12'h020; ram_val = 12'h3C3;
    for (int k = 1; k <= 20; k++) begin
      tick();
`ifdef Q2_ARB_RR_EN
      exp_dma = ((k - 1) / 5) % 2 == 1;
`else
      exp_dma = 1'b0;
`endif
      chk($sformatf("ct_cack_k%0d", k), cpu_ack, (k % 5 == 4) && !exp_dma);
      chk($sformatf("ct_dack_k%0d", k), dma_ack, (k % 5 == 4) && exp_dma);
      chk($sformatf("ct_busy_k%0d", k), busy, (k % 5 != 0));
      if (k % 5 == 1) begin
        chk($sformatf("ct_grant_k%0d", k), grant, exp_dma);
        chk($sformatf("ct_addr_k%0d", k), ram_addr, exp_dma ? 12'h020 : 12'h010);
      end
      if (k == 19) begin
        cpu_req = 1'b0; dma_req = 1'b0;
      end
    end
    chk("ct_cpu_rdata", cpu_rdata, 12'h3C3);
`ifdef Q2_ARB_RR_EN
    chk("ct_dma_rdata", dma_rdata, 12'h3C3);
`else
    chk("ct_dma_rdata", dma_rdata, 12'h000);
`endif

    // Request withdrawal: cpu_req high for a single sampled edge
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h055; ram_val = 12'h0F0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) cpu_req = 1'b0;
      chk($sformatf("wd_ack_k%0d", k), cpu_ack, (k == 4));
      chk($sformatf("wd_busy_k%0d", k), busy, (k <= 4));
    end
    chk("wd_cpu_rdata", cpu_rdata, 12'h0F0);

    // Reset mid-write: DMA write, rst low for two cycles during STROBE
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 12'h100; dma_wdata = 12'h2AA;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("rm_dack_k%0d", k), dma_ack, 0);
      if (k == 2) begin
        chk("rm_we_before", ram_we, 1);
        rst = 1'b0; dma_req = 1'b0;
      end
      if (k == 3) begin
        chk("rm_we", ram_we, 0);
        chk("rm_ce", ram_ce, 0);
        chk("rm_drive", ram_drive, 0);
        chk("rm_busy", busy, 0);
        chk("rm_grant", grant, 0);
        chk("rm_addr", ram_addr, 12'h000);
        chk("rm_wdata", ram_wdata, 12'h000);
        chk("rm_cpu_rdata", cpu_rdata, 12'h000);
      end
      if (k == 4) rst = 1'b1;
      if (k >= 5) chk($sformatf("rm_busy_k%0d", k), busy, 0);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h321; ram_val = 12'h456;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("rr_ack_k%0d", k), cpu_ack, (k == 4));
      chk($sformatf("rr_oe_k%0d", k), ram_oe, (k == 2 || k == 3));
      if (k == 4) begin
        chk("rr_cpu_rdata", cpu_rdata, 12'h456);
        cpu_req = 1'b0;
      end
    end

    // Parameter sweep: 3/1 and 4/8 instances
    cpu_addr = 12'h0AA; ram_val = 12'h9E1;
    req_b = 1'b1; req_c = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("sb_oe_k%0d", k), oe_b, (k == 4));
      chk($sformatf("sb_ack_k%0d", k), ack_b, (k == 5));
      chk($sformatf("sb_ce_k%0d", k), ce_b, (k <= 5));
      chk($sformatf("sc_oe_k%0d", k), oe_c, (k >= 5 && k <= 12));
      chk($sformatf("sc_ack_k%0d", k), ack_c, (k == 13));
      chk($sformatf("sc_busy_k%0d", k), busy_c, (k <= 13));
      if (k == 5) begin
        chk("sb_rdata", rd_b, 12'h9E1);
        req_b = 1'b0;
      end
      if (k == 13) begin
        chk("sc_rdata", rd_c, 12'h9E1);
        req_c = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
